// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and
// the instruction memory.
//   imem_req    : request valid, held with imem_addr until imem_gnt
//   imem_addr   : request address
//   imem_gnt    : request accepted this cycle
//   imem_rvalid : read data valid (no earlier than the cycle after gnt)
//   imem_rdata  : read data
// Modports: master (fetch controller), slave (memory).
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-memory request at a
// time, delivers the fetched word to decode and handles PC redirects.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start           : fetch enable (level)
//   PC_jump         : redirect pulse, PC_branch is the target
//   id_ready        : decode accepts the held instruction
//   imem            : instruction-memory bus (fetch_ctrl_if.master)
//   if_valid/PC/PC_plus4/inst : delivered instruction
//   misalign        : misaligned-redirect fault flag
// Optional feature: define FETCH_CTRL_MISALIGN_EN to trap misaligned
// redirect targets in a FAULT state; otherwise targets are word-aligned by
// dropping the low two bits and misalign is constant 0.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         PC_jump,
    input  logic [31:0]  PC_branch,
    input  logic         id_ready,
    fetch_ctrl_if.master imem,
    output logic         if_valid,
    output logic [31:0]  PC,
    output logic [31:0]  PC_plus4,
    output logic [31:0]  inst,
    output logic         misalign
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0]  state;
    logic [31:0] fetch_pc;
    logic        kill;     // response of the outstanding request must be dropped
    logic [31:0] target;

    // Only used when the target is aligned, so masking is harmless with the
    // fault feature enabled and is the alignment rule without it.
    assign target = PC_branch & 32'hFFFF_FFFC;

    assign imem.imem_req  = (state == S_REQ);
    assign imem.imem_addr = (state == S_REQ) ? fetch_pc : 32'h0;

`ifdef FETCH_CTRL_MISALIGN_EN
    logic misalign_q;
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            kill     <= 1'b0;
            if_valid <= 1'b0;
            PC       <= 32'h0;
            PC_plus4 <= 32'h0;
            inst     <= 32'h0;
`ifdef FETCH_CTRL_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else if (PC_jump) begin
            // Redirect wins over every other event this cycle.
            if_valid <= 1'b0;
`ifdef FETCH_CTRL_MISALIGN_EN
            if (PC_branch[1:0] != 2'b00) begin
                state      <= S_FAULT;
                kill       <= 1'b0;
                misalign_q <= 1'b1;
            end else
`endif
            begin
`ifdef FETCH_CTRL_MISALIGN_EN
                misalign_q <= 1'b0;
`endif
                fetch_pc <= target;
                case (state)
                    S_REQ: begin
                        // Granted old address: its response must be dropped.
                        if (imem.imem_gnt) begin
                            kill  <= 1'b1;
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        // A response arriving now is dropped on the spot.
                        if (imem.imem_rvalid) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            kill  <= 1'b1;
                        end
                    end
                    default: begin
                        kill  <= 1'b0;
                        state <= start ? S_REQ : S_IDLE;
                    end
                endcase
            end
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_REQ;
                S_REQ:  if (imem.imem_gnt) state <= S_WAIT;
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            inst     <= imem.imem_rdata;
                            PC       <= fetch_pc;
                            PC_plus4 <= fetch_pc + 32'd4;
                            if_valid <= 1'b1;
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        if_valid <= 1'b0;
                        state    <= start ? S_REQ : S_IDLE;
                    end
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
